// File: rtl/apb_master.sv
// apb_master: APB4 requester that turns a valid/ready command port into
// SETUP/ACCESS transfers, one at a time, with one response per command.
// Optional feature: define APB_MASTER_TIMEOUT_EN to bound the ACCESS phase
// to TIMEOUT_CYCLES wait edges; without it ACCESS waits for PREADY forever.
//
// Handshake: a command transfers on a rising PCLK edge where
// cmd_valid && cmd_ready. cmd_ready is high in IDLE, and in ACCESS it follows
// PREADY so the next command hands off on the completion edge. rsp_valid is a
// single-cycle pulse with no backpressure.
module apb_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int STRB_WIDTH     = DATA_WIDTH / 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic [STRB_WIDTH-1:0] cmd_strb,
    input  logic [2:0]            cmd_prot,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    output logic [STRB_WIDTH-1:0] PSTRB,
    output logic [2:0]            PPROT,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t state;
    logic   accept;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    // Value held on the edge that would be the TIMEOUT_CYCLES-th wait edge.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] wait_cnt;
`endif

    // Ready is held low while reset is applied so nothing is accepted then.
    assign cmd_ready = !PRESET && ((state == IDLE) || ((state == ACCESS) && PREADY));
    assign accept    = cmd_valid && cmd_ready;

    // Request registers: capture a command on handshake and hold it between
    // transfers; reads always present zero strobes to the completer.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            PADDR  <= '0;
            PWDATA <= '0;
            PWRITE <= 1'b0;
            PSTRB  <= '0;
            PPROT  <= 3'd0;
        end else if (accept) begin
            PADDR  <= cmd_addr;
            PWDATA <= cmd_wdata;
            PWRITE <= cmd_write;
            PSTRB  <= cmd_write ? cmd_strb : '0;
            PPROT  <= cmd_prot;
        end
    end

    // Transfer sequencer: IDLE -> SETUP -> ACCESS, with registered bus
    // control and a registered response pulse on completion.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state     <= IDLE;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
            wait_cnt  <= '0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    PSEL    <= 1'b0;
                    PENABLE <= 1'b0;
                    if (accept) begin
                        PSEL  <= 1'b1;
                        state <= SETUP;
                    end
                end
                SETUP: begin
                    PENABLE <= 1'b1;
                    state   <= ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end
                ACCESS: begin
                    if (PREADY) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= PSLVERR;
                        rsp_rdata <= PWRITE ? '0 : PRDATA;
                        PENABLE   <= 1'b0;
                        if (accept) begin
                            state <= SETUP;
                        end else begin
                            PSEL  <= 1'b0;
                            state <= IDLE;
                        end
                    end
`ifdef APB_MASTER_TIMEOUT_EN
                    else if (wait_cnt == CNT_LAST) begin
                        // Completer never answered: abandon the transfer.
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
`endif
                end
                default: begin
                    PSEL    <= 1'b0;
                    PENABLE <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: directed and randomized checks of apb_master against a
// transaction-level reference (expected response queue plus a word memory).
module tb_apb_master;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int TO = 16;
  localparam int RW = 65;  // {completion edge[31:0], err, rdata[31:0]}

  `define CHK(TAG, OBS, EXP) begin tests++; assert ((OBS) === (EXP)) else begin fails++; $error("FAIL %s: observed 0x%0h expected 0x%0h", TAG, (OBS), (EXP)); end end

  logic          PCLK = 1'b0;
  logic          PRESET;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [SW-1:0] cmd_strb;
  logic [2:0]    cmd_prot;
  logic          rsp_valid, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          PSEL, PENABLE, PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic [SW-1:0] PSTRB;
  logic [2:0]    PPROT;
  logic [DW-1:0] PRDATA;
  logic          PREADY, PSLVERR;

  apb_master #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  // ---------------- clock / reset ----------------
  always #5 PCLK = ~PCLK;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not complete, observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  typedef struct { int waits; bit err; } cfg_t;
  cfg_t          cfg_q[$];
  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] rsp_q[$];
  logic [RW-1:0] last_exp = '0;
  logic [31:0]   ref_mem [logic [31:0]];
  logic [31:0]   bus_mem [logic [31:0]];

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  function automatic logic [31:0] bus_rd(input logic [31:0] a);
    return bus_mem.exists(a) ? bus_mem[a] : 32'h0;
  endfunction

  // ---------------- completer stub ----------------
  // Answers just after each rising edge using the per-transfer config at the
  // head of cfg_q; flags an error on reads with nonzero strobes.
  int wcnt;
  initial begin
    PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0; wcnt = 0;
    forever begin
      @(posedge PCLK); #1;
      if (!PRESET && PSEL && PENABLE && cfg_q.size() > 0) begin
        if (wcnt < cfg_q[0].waits) begin
          PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = $urandom; wcnt++;
        end else begin
          PREADY  = 1'b1;
          PSLVERR = cfg_q[0].err || (!PWRITE && PSTRB != 4'h0);
          PRDATA  = PWRITE ? $urandom : bus_rd(PADDR);
        end
      end else begin
        PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = $urandom; wcnt = 0;
      end
    end
  end

  // ---------------- monitor ----------------
  int          acc_cnt = 0;
  int          stab_bad = 0;
  logic        prev_acc = 1'b0, prev_rdy = 1'b0;
  logic [71:0] prev_req = '0;
  always @(negedge PCLK) begin
    if (!PRESET) begin
      if (PSEL && PENABLE && PREADY && cfg_q.size() > 0) begin
        if (PWRITE && !PSLVERR) bus_mem[PADDR] = merge(bus_rd(PADDR), PWDATA, PSTRB);
        void'(cfg_q.pop_front());
      end
      if (rsp_valid) rsp_q.push_back({32'(cyc), rsp_err, rsp_rdata});
      if (PSEL && PENABLE) begin
        acc_cnt++;
        if (prev_acc && !prev_rdy && {PADDR, PWDATA, PWRITE, PSTRB, PPROT} != prev_req) stab_bad++;
      end
    end
    prev_acc = PSEL && PENABLE;
    prev_rdy = PREADY;
    prev_req = {PADDR, PWDATA, PWRITE, PSTRB, PPROT};
  end

  // ---------------- driver tasks ----------------
  // Called at a falling edge; returns at the falling edge inside SETUP with
  // cmd_valid still high so the caller may chain a back-to-back command.
  task automatic issue(input bit w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [2:0] p, input int waits,
                       input bit err, input bit stuck, output int acc_edge);
    cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_strb = s; cmd_prot = p;
    cmd_valid = 1'b1;
    if (!stuck) cfg_q.push_back('{waits, err});
    for (int n = 0; n < 200 && !cmd_ready; n++) @(negedge PCLK);
    `CHK("accept", cmd_ready, 1'b1)
    acc_edge = cyc + 1;
    if (!stuck) begin
      exp_q.push_back({32'(acc_edge + 2 + waits), err, w ? 32'h0 : ref_rd(a)});
      if (w && !err) ref_mem[a] = merge(ref_rd(a), d, s);
    end
    @(posedge PCLK);
    @(negedge PCLK);
    `CHK("setup_ctrl", {PSEL, PENABLE}, 2'b10)
    `CHK("setup_addr", PADDR, a)
    `CHK("setup_write", PWRITE, w)
    `CHK("setup_strb", PSTRB, (w ? s : 4'h0))
    `CHK("setup_prot", PPROT, p)
    `CHK("setup_wdata", PWDATA, d)
  endtask

  // Scoreboard: wait for every expected response, then compare in order.
  task automatic drain();
    logic [RW-1:0] e, o;
    int n = 0;
    while (rsp_q.size() < exp_q.size() && n < 400) begin @(negedge PCLK); n++; end
    repeat (3) @(negedge PCLK);
    `CHK("rsp_count", rsp_q.size(), exp_q.size())
    while (exp_q.size() > 0 && rsp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = rsp_q.pop_front();
      `CHK("rsp_edge", o[64:33], e[64:33])
      `CHK("rsp_err", o[32], e[32])
      `CHK("rsp_rdata", o[31:0], e[31:0])
      last_exp = e;
    end
    exp_q.delete();
    rsp_q.delete();
    `CHK("rsp_hold", {rsp_valid, rsp_err, rsp_rdata}, {1'b0, last_exp[32:0]})
  endtask

  // ---------------- directed + random sequence ----------------
  int acc;
  int acc_e[4];
  bit w;
  initial begin
    PRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0;
    cmd_addr = '0; cmd_wdata = '0; cmd_strb = '0; cmd_prot = '0;

    // reset state
    repeat (3) @(negedge PCLK);
    `CHK("rst_ctrl", {cmd_ready, PSEL, PENABLE, PWRITE}, 4'b0000)
    `CHK("rst_req", {PADDR, PWDATA, PSTRB, PPROT}, 71'd0)
    `CHK("rst_rsp", {rsp_valid, rsp_err, rsp_rdata}, 34'd0)
    PRESET = 1'b0;
    @(negedge PCLK);
    `CHK("idle_ready", {cmd_ready, PSEL, PENABLE}, 3'b100)

    // write then read
    issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3'd0, 0, 1'b0, 1'b0, acc);
    cmd_valid = 1'b0;
    drain();
    issue(1'b0, 32'h10, 32'h0, 4'h0, 3'd2, 0, 1'b0, 1'b0, acc);
    cmd_valid = 1'b0;
    drain();

    // read with strobes set: bus must see zero strobes
    issue(1'b0, 32'h10, 32'h1234, 4'hF, 3'd1, 0, 1'b0, 1'b0, acc);
    cmd_valid = 1'b0;
    drain();

    // back-to-back writes
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, 32'h20 + 32'(4 * i), $urandom, 4'hF, 3'(i), 0, 1'b0, 1'b0, acc_e[i]);
      @(negedge PCLK);
      `CHK("b2b_access", {PSEL, PENABLE}, 2'b11)
      if (i == 3) cmd_valid = 1'b0;
    end
    for (int i = 1; i < 4; i++) `CHK("b2b_spacing", acc_e[i] - acc_e[i-1], 2)
    drain();

    // wait states with slave error
    acc_cnt = 0; stab_bad = 0;
    issue(1'b1, 32'h24, 32'hCAFEF00D, 4'h3, 3'd5, 3, 1'b1, 1'b0, acc);
    cmd_valid = 1'b0;
    drain();
    `CHK("wait_access_cycles", acc_cnt, 4)
    `CHK("wait_stable", stab_bad, 0)

    // randomized traffic, mixed gaps and back-to-back
    stab_bad = 0;
    for (int i = 0; i < 24; i++) begin
      w = 1'($urandom_range(0, 1));
      issue(w, 32'($urandom_range(0, 7)) << 2, $urandom, 4'($urandom), 3'($urandom),
            $urandom_range(0, 3), ($urandom_range(0, 5) == 0), 1'b0, acc);
      if ($urandom_range(0, 1) == 1) begin
        cmd_valid = 1'b0;
        drain();
      end
    end
    cmd_valid = 1'b0;
    drain();
    `CHK("rand_stable", stab_bad, 0)

    // completer never answers
`ifdef APB_MASTER_TIMEOUT_EN
    issue(1'b0, 32'h44, 32'h0, 4'h0, 3'd0, 0, 1'b0, 1'b1, acc);
    cmd_valid = 1'b0;
    exp_q.push_back({32'(acc + 1 + TO), 1'b1, 32'h0});
    drain();
    `CHK("timeout_idle", {cmd_ready, PSEL, PENABLE}, 3'b100)
    issue(1'b1, 32'h30, 32'h55555555, 4'hF, 3'd0, 0, 1'b0, 1'b1, acc);
    cmd_valid = 1'b0;
    repeat (5) @(negedge PCLK);
    `CHK("stuck_access", {PSEL, PENABLE}, 2'b11)
`else
    issue(1'b1, 32'h30, 32'h55555555, 4'hF, 3'd0, 0, 1'b0, 1'b1, acc);
    cmd_valid = 1'b0;
    repeat (100) @(negedge PCLK);
    `CHK("stuck_access", {PSEL, PENABLE}, 2'b11)
    `CHK("stuck_no_rsp", rsp_q.size(), 0)
`endif

    // reset in the middle of ACCESS
    #2 PRESET = 1'b1;
    #1;
    `CHK("abort_ctrl", {PSEL, PENABLE}, 2'b00)
    repeat (2) @(negedge PCLK);
    `CHK("abort_no_rsp", rsp_q.size(), 0)
    `CHK("abort_req", {PADDR, PWDATA, PSTRB, PPROT, PWRITE}, 72'd0)
    `CHK("abort_rsp", {rsp_valid, rsp_err, rsp_rdata}, 34'd0)
    cfg_q.delete();
    last_exp = '0;
    PRESET = 1'b0;
    @(negedge PCLK);
    `CHK("abort_ready", cmd_ready, 1'b1)

    // recovery: the aborted write never landed, a fresh one does
    issue(1'b0, 32'h30, 32'h0, 4'h0, 3'd0, 0, 1'b0, 1'b0, acc);
    cmd_valid = 1'b0;
    drain();
    issue(1'b1, 32'h30, 32'hA5A50F0F, 4'hF, 3'd0, 1, 1'b0, 1'b0, acc);
    cmd_valid = 1'b0;
    drain();
    issue(1'b0, 32'h30, 32'h0, 4'h0, 3'd0, 0, 1'b0, 1'b0, acc);
    cmd_valid = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
